// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: synchronizes rxd, samples mid-bit from a
// programmable divider and delivers bytes on a valid/ready handshake.
module uart_rx_deser #(
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic                   fire;

  assign rxd_s = sync[SYNC_STAGES-1];
  assign fire  = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rxd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A delivery later in this block overrides this clear.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= HALF;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (fire) begin
            if (!rxd_s) begin
              cnt     <= FULL;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (fire) begin
            shift   <= {rxd_s, shift[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (fire) begin
            if (rxd_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BRK: begin
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
